// File: rtl/wb_port_arbiter.sv
// Round-robin writeback-port arbiter: N_REQ requesters share one registered output stage.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.

module wb_arb_en_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= d;
  end
endmodule

module wb_port_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [SRC_W-1:0]       out_src
);

  logic             load_en_p0;
  logic             any_valid_p0;
  logic [SRC_W-1:0] grant_p0;
  logic [SRC_W-1:0] ptr;
  logic             xfer_p0;
  logic [WIDTH-1:0] sel_data_p0;
  logic [TAG_W-1:0] sel_tag_p0;

  // Stage p0: combinational grant selection and handshake
  assign load_en_p0 = !out_valid || out_ready;

  always_comb begin
    int idx;
    grant_p0     = '0;
    any_valid_p0 = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_valid_p0 && req_valid[idx]) begin
        grant_p0     = SRC_W'(idx);
        any_valid_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && load_en_p0 && any_valid_p0) req_ready[grant_p0] = 1'b1;
  end

  assign xfer_p0     = rst && load_en_p0 && any_valid_p0;
  assign sel_data_p0 = req_data[grant_p0*WIDTH +: WIDTH];
  assign sel_tag_p0  = req_tag[grant_p0*TAG_W +: TAG_W];

  // Stage p1: output register bank and priority pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_valid <= 1'b0;
    else if (load_en_p0) out_valid <= any_valid_p0;
  end

  wb_arb_en_reg #(.W(WIDTH)) data_reg (
    .clk(clk), .rst(rst), .en(xfer_p0), .d(sel_data_p0), .q(out_data)
  );

  wb_arb_en_reg #(.W(TAG_W)) tag_reg (
    .clk(clk), .rst(rst), .en(xfer_p0), .d(sel_tag_p0), .q(out_tag)
  );

  wb_arb_en_reg #(.W(SRC_W)) src_reg (
    .clk(clk), .rst(rst), .en(xfer_p0), .d(grant_p0), .q(out_src)
  );

`ifdef WB_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SRC_W-1:0] ptr_nxt;
  // Pointer moves just past the winner so that requester drops to lowest priority
  assign ptr_nxt = (int'(grant_p0) == N_REQ - 1) ? '0 : grant_p0 + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else if (xfer_p0) ptr <= ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a per-cycle reference model and literal checkpoints.
module tb_wb_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 6;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*T-1:0] req_tag;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [T-1:0]   out_tag;
  logic [S-1:0]   out_src;

  logic [W-1:0] dv [N];
  logic [T-1:0] tv [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_tag  = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = dv[i];
      req_tag[i*T +: T]  = tv[i];
    end
  end

  wb_port_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_src(out_src)
  );

  // Reference model: the held writeback plus whose turn it is
  bit           m_valid;
  logic [W-1:0] m_data;
  logic [T-1:0] m_tag;
  int           m_src;
  int           m_turn;

  function automatic int pick();
    if (!rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      if (req_valid[k]) return k;
`else
      if (req_valid[(m_turn + k) % N]) return (m_turn + k) % N;
`endif
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int g;
    if (!rst) begin
      m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_turn = 0;
    end else if (!m_valid || out_ready) begin
      g = pick();
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = dv[g]; m_tag = tv[g]; m_src = g; m_turn = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    tests++;
    if (req_ready !== er || out_valid !== m_valid || out_data !== m_data ||
        out_tag !== m_tag || int'(out_src) != m_src) begin
      fails++;
      $display("FAIL model t=%0t ready=%b/%b valid=%b/%b data=%h/%h tag=%h/%h src=%0d/%0d",
               $time, req_ready, er, out_valid, m_valid, out_data, m_data,
               out_tag, m_tag, out_src, m_src);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dv[i] = 32'hA0 + i;
      tv[i] = T'(10 + i);
    end
    req_valid = 4'b1111;
    out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_src", out_src, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b1;
    #1 check("first_grant", req_ready, 4'b0001);

`ifndef WB_ARB_FIXED_PRIO_EN
    // Rotation
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rot_src", out_src, c % 4);
      check("rot_data", out_data, 32'hA0 + (c % 4));
    end
    // Backpressure (ptr now 2)
    req_valid = 4'b0001; dv[0] = 32'h55; tv[0] = 6'd5;
    tick();
    check("bp_load_data", out_data, 32'h55);
    out_ready = 1'b0; req_valid = 4'b0100; dv[2] = 32'h77; tv[2] = 6'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 32'h55);
      check("bp_hold_tag", out_tag, 5);
      check("bp_no_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b0100);
    tick();
    check("bp_new_data", out_data, 32'h77);
    check("bp_new_src", out_src, 2);
    // Sparse / wrap (ptr now 3)
    req_valid = 4'b0010; dv[1] = 32'h11;
    #1 check("sparse_ready1", req_ready, 4'b0010);
    tick();
    check("sparse_src1", out_src, 1);
    req_valid = 4'b1000; dv[3] = 32'h33;
    #1 check("sparse_ready3", req_ready, 4'b1000);
    tick();
    check("sparse_src3", out_src, 3);
    req_valid = 4'b1001;
    #1 check("wrap_ready0", req_ready, 4'b0001);
    // Idle drain
    tick();
    check("drain_src", out_src, 0);
    req_valid = 4'b0000;
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_data_held", out_data, 32'h55);
    tick();
    check("drain_still_idle", out_valid, 0);
    // Reset mid-transfer (ptr now 1)
    req_valid = 4'b1111;
    tick();
    check("mid_src", out_src, 1);
    rst = 1'b0;
    #1 check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    rst = 1'b1;
    #1 check("post_rst_ready", req_ready, 4'b0001);
    tick();
    check("post_rst_src", out_src, 0);
    check("post_rst_data", out_data, 32'h55);
`else
    req_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      #1 check("fp_ready", req_ready, 4'b0001);
      tick();
      check("fp_src", out_src, 0);
    end
`endif
    req_valid = '0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Round-robin arbiter that shares one register-file writeback port among N_REQ functional-unit requesters.
- Each cycle it selects at most one valid request and captures its data, tag and source index into an internal output register bank built from the team's write-enabled register cells.
- That register bank feeds the physical register file write port and the wakeup/bypass network.
- Valid/ready handshake on both sides; full throughput (one grant per cycle) and 1-cycle latency.

Parameters:
- N_REQ, 4, number of requesters (≥1).
- WIDTH, 32, writeback data width in bits.
- TAG_W, 6, destination physical-register tag width.
- SRC_W, $clog2(N_REQ) (min 1), width of the source-index output; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester grant/accept; one-hot or zero.
- req_data  input  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_tag  input  N_REQ*TAG_W  requester i tag in bits [i*TAG_W +: TAG_W].
- out_valid  output  1  output register holds a valid writeback.
- out_ready  input  1  downstream write port accepts this cycle.
- out_data  output  WIDTH  registered winner data.
- out_tag  output  TAG_W  registered winner tag.
- out_src  output  SRC_W  index of the requester that produced the current output.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, out_tag=0, out_src=0, priority pointer ptr=0. The held output entry is discarded. req_ready is 0 while rst=0.
- load_en = !out_valid | out_ready. This is combinational; the output stage is a 1-entry pipeline register.
- Grant selection (combinational): scan indices ptr, ptr+1, … mod N_REQ and pick the first i with req_valid[i]=1.
- req_ready[i] = load_en & (i == winner) & any_valid. At most one bit is set.
- No handshake-to-handshake loop: req_ready may depend on out_ready. req_valid must not depend on req_ready.
- Transfer on requester i: req_valid[i] & req_ready[i].
- On a transfer, the next edge sets out_valid=1, out_data=req_data[i], out_tag=req_tag[i], out_src=i, and ptr=(i+1) mod N_REQ. ptr wraps from N_REQ-1 to 0.
- load_en=1 with no valid request: next edge sets out_valid=0. Data, tag and src hold their old values. ptr unchanged.
- load_en=0 (out_valid=1, out_ready=0): output holds all fields; no req_ready is asserted; ptr unchanged.
- Latency: a request accepted in cycle t appears on out_* in cycle t+1.
- Back-to-back: out_ready held 1 sustains one transfer per cycle with no bubbles.
- Requester protocol: once req_valid[i]=1 it stays 1 with stable data/tag until accepted. The arbiter does not buffer rejected requests.
- Fairness: with all N_REQ valid continuously and out_ready=1, grants rotate strictly 0,1,…,N_REQ-1,0,…. Any continuously-valid requester is granted within N_REQ accepted transfers.
- N_REQ=1: degenerates to a registered valid/ready pipe stage; ptr constant 0; out_src=0.
- Simultaneous out_ready and new grant: the old output retires and the new one is loaded on the same edge.
- Reset asserted mid-transfer: the pending output is lost. After rst deasserts, the first grant goes to the lowest-index valid requester.

Optional Feature:
- Macro WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins; ptr is not implemented and is held at 0. Starvation is permitted by design. All handshake and latency rules are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: drive rst=0 with all req_valid=1 → out_valid=0, out_data=0, out_tag=0, out_src=0, req_ready=0. Release rst with all valid → first grant to req 0, and out_src=0 one cycle later.
- Rotation: N_REQ=4, all valid continuously, out_ready=1, distinct data 0xA0..0xA3 → out_src sequence 0,1,2,3,0,1 over 6 cycles; out_data follows A0,A1,A2,A3,A0,A1.
- Backpressure: out_valid=1 (data 0x55, tag 5), out_ready=0 for 3 cycles with req 2 valid → outputs stable, req_ready=0. When out_ready=1, req_ready[2]=1 the same cycle, and out_data=req2 data next cycle.
- Sparse/wrap: ptr=3, only req 1 valid → grant 1, ptr becomes 2. Next cycle only req 3 valid → grant 3, ptr wraps to 0.
- Idle drain: one transfer, then no requests and out_ready=1 → out_valid drops to 0 the next cycle; out_data retains its last value.
- WB_ARB_FIXED_PRIO_EN defined, reqs 0 and 3 valid for 4 cycles → req 0 is granted every cycle; req 3 is never granted.
